// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline package: Tuse/Tnew encodings, default MDU latencies and
// the MDU state type. Used by the hazard controller, the pipeline
// registers and the decoder.
package pipe_hazard_ctrl_pkg;

  // Tuse: cycles until a D-stage operand is consumed; TUSE_NONE = unused
  localparam logic [1:0] TUSE_0    = 2'd0;
  localparam logic [1:0] TUSE_1    = 2'd1;
  localparam logic [1:0] TUSE_2    = 2'd2;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  // Tnew: cycles until a producing instruction's result is available
  localparam logic [1:0] TNEW_0 = 2'd0;
  localparam logic [1:0] TNEW_1 = 2'd1;
  localparam logic [1:0] TNEW_2 = 2'd2;

  // Default multiply/divide unit occupancy in cycles
  localparam int unsigned MULT_CYC_DEF = 5;
  localparam int unsigned DIV_CYC_DEF  = 10;

  // Width of the MDU remaining-cycles counter
  localparam int unsigned MD_CNT_W = 4;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

endpackage

// File: rtl/md_busy_ctr.sv
// Multiply/divide unit occupancy tracker.
// A start in IDLE loads the busy counter with the mult or div latency and
// enters BUSY; BUSY counts down to IDLE. A start while BUSY is dropped and
// raises a sticky error flag.
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-low reset
//   start  in   mult/div issues this cycle
//   div    in   qualifies start: 1 = div, 0 = mult
//   busy   out  MDU occupied (registered)
//   cnt    out  remaining busy cycles
//   err    out  sticky: start arrived while busy
module md_busy_ctr
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYC = MULT_CYC_DEF,
  parameter int unsigned DIV_CYC  = DIV_CYC_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                div,
  output logic                busy,
  output logic [MD_CNT_W-1:0] cnt,
  output logic                err
);

  localparam logic [MD_CNT_W-1:0] MULT_LD = MD_CNT_W'(MULT_CYC);
  localparam logic [MD_CNT_W-1:0] DIV_LD  = MD_CNT_W'(DIV_CYC);
  localparam logic [MD_CNT_W-1:0] CNT_ONE = MD_CNT_W'(1);

  md_state_t           state_q, state_d;
  logic [MD_CNT_W-1:0] cnt_q, cnt_d;
  logic                err_q, err_d;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      MD_IDLE: begin
        if (start) begin
          state_d = MD_BUSY;
          cnt_d   = div ? DIV_LD : MULT_LD;
        end
      end
      MD_BUSY: begin
        if (start) err_d = 1'b1;
        // <= also covers a zero latency load so BUSY can never stick
        if (cnt_q <= CNT_ONE) begin
          state_d = MD_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = MD_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs
  always_comb begin
    busy = (state_q == MD_BUSY);
    cnt  = cnt_q;
    err  = err_q;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: Tuse/Tnew register hazard detection for the
// two D-stage operands against the E and M stage producers, plus an MDU
// hazard while the multiply/divide unit is (or is about to be) busy.
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   rs_D, rt_D, tuse_rs_D/rt_D D-stage operands and their Tuse
//   A3_E, tnew_E, RegWrite_E   E-stage destination info
//   A3_M, tnew_M, RegWrite_M   M-stage destination info
//   md_start_E, md_div_E       mult/div issue in E and its kind
//   md_use_D                   D-stage instruction uses HI/LO or the MDU
//   stall, en_PC, en_D, clr_E  combinational stall and pipeline controls
//   md_busy, md_cnt, md_err    MDU occupancy status
//   stall_cnt                  saturating count of stall cycles
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYC = MULT_CYC_DEF,
  parameter int unsigned DIV_CYC  = DIV_CYC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs_D,
  input  logic [4:0]  rt_D,
  input  logic [1:0]  tuse_rs_D,
  input  logic [1:0]  tuse_rt_D,
  input  logic [4:0]  A3_E,
  input  logic [4:0]  A3_M,
  input  logic [1:0]  tnew_E,
  input  logic [1:0]  tnew_M,
  input  logic        RegWrite_E,
  input  logic        RegWrite_M,
  input  logic        md_start_E,
  input  logic        md_div_E,
  input  logic        md_use_D,
  output logic        stall,
  output logic        en_PC,
  output logic        en_D,
  output logic        clr_E,
  output logic        md_busy,
  output logic [3:0]  md_cnt,
  output logic        md_err,
  output logic [31:0] stall_cnt
);

  logic        hz_rs, hz_rt, hz_md;
  logic [31:0] stall_q;

  // E and M matches are ORed: either producer alone is enough to stall
  function automatic logic op_hazard(
    input logic [4:0] r,
    input logic [1:0] tuse,
    input logic       rw_e,
    input logic [4:0] a3_e,
    input logic [1:0] tn_e,
    input logic       rw_m,
    input logic [4:0] a3_m,
    input logic [1:0] tn_m
  );
    return (tuse != TUSE_NONE) && (r != 5'd0) &&
           ((rw_e && (a3_e == r) && (tn_e > tuse)) ||
            (rw_m && (a3_m == r) && (tn_m > tuse)));
  endfunction

  md_busy_ctr #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC)
  ) u_md_busy_ctr (
    .clk   (clk),
    .reset (reset),
    .start (md_start_E),
    .div   (md_div_E),
    .busy  (md_busy),
    .cnt   (md_cnt),
    .err   (md_err)
  );

  always_comb begin
    hz_rs = op_hazard(rs_D, tuse_rs_D, RegWrite_E, A3_E, tnew_E,
                      RegWrite_M, A3_M, tnew_M);
    hz_rt = op_hazard(rt_D, tuse_rt_D, RegWrite_E, A3_E, tnew_E,
                      RegWrite_M, A3_M, tnew_M);
    // md_start_E counts too: md_busy only rises the cycle after issue
    hz_md = md_use_D && (md_busy || md_start_E);
    stall = hz_rs || hz_rt || hz_md;
    en_PC = !stall;
    en_D  = !stall;
    clr_E = stall;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
    end else if (stall && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs_D, rt_D, A3_E, A3_M;
  logic [1:0]  tuse_rs_D, tuse_rt_D, tnew_E, tnew_M;
  logic        RegWrite_E, RegWrite_M, md_start_E, md_div_E, md_use_D;
  logic        stall, en_PC, en_D, clr_E, md_busy, md_err;
  logic [3:0]  md_cnt;
  logic [31:0] stall_cnt;

  pipe_hazard_ctrl #(
    .MULT_CYC (5),
    .DIV_CYC  (10)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rs_D       (rs_D),
    .rt_D       (rt_D),
    .tuse_rs_D  (tuse_rs_D),
    .tuse_rt_D  (tuse_rt_D),
    .A3_E       (A3_E),
    .A3_M       (A3_M),
    .tnew_E     (tnew_E),
    .tnew_M     (tnew_M),
    .RegWrite_E (RegWrite_E),
    .RegWrite_M (RegWrite_M),
    .md_start_E (md_start_E),
    .md_div_E   (md_div_E),
    .md_use_D   (md_use_D),
    .stall      (stall),
    .en_PC      (en_PC),
    .en_D       (en_D),
    .clr_E      (clr_E),
    .md_busy    (md_busy),
    .md_cnt     (md_cnt),
    .md_err     (md_err),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic        st;
    logic        bz;
    logic [3:0]  c;
    logic        er;
    logic [31:0] sc;
  } exp_t;

  exp_t        q[$];
  logic [31:0] exp_scnt = '0;
  bit          done = 1'b0;
  int          total = 0;
  int          bad = 0;

  task automatic clr_in();
    rs_D = '0; rt_D = '0; A3_E = '0; A3_M = '0;
    tuse_rs_D = 2'd3; tuse_rt_D = 2'd3; tnew_E = '0; tnew_M = '0;
    RegWrite_E = 1'b0; RegWrite_M = 1'b0;
    md_start_E = 1'b0; md_div_E = 1'b0; md_use_D = 1'b0;
  endtask

  // Push the expected response for the cycle just driven, then advance.
  task automatic step(input string nm, input logic st, input logic bz,
                      input logic [3:0] c, input logic er);
    exp_t e;
    if (!reset) exp_scnt = '0;
    e.nm = nm; e.st = st; e.bz = bz; e.c = c; e.er = er; e.sc = exp_scnt;
    q.push_back(e);
    @(posedge clk);
    if (reset && st && (exp_scnt != 32'hFFFF_FFFF)) exp_scnt = exp_scnt + 32'd1;
    #1;
  endtask

  task automatic chk(input string nm, input string f,
                     input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s.%s got=%0h want=%0h", nm, f, act, want);
    end
  endtask

  // Monitor: compares DUT outputs mid-cycle against the queued expectation
  initial begin
    exp_t e;
    int   cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk(e.nm, "stall",     {31'd0, stall},   {31'd0, e.st});
        chk(e.nm, "en_PC",     {31'd0, en_PC},   {31'd0, ~e.st});
        chk(e.nm, "en_D",      {31'd0, en_D},    {31'd0, ~e.st});
        chk(e.nm, "clr_E",     {31'd0, clr_E},   {31'd0, e.st});
        chk(e.nm, "md_busy",   {31'd0, md_busy}, {31'd0, e.bz});
        chk(e.nm, "md_cnt",    {28'd0, md_cnt},  {28'd0, e.c});
        chk(e.nm, "md_err",    {31'd0, md_err},  {31'd0, e.er});
        chk(e.nm, "stall_cnt", stall_cnt,        e.sc);
      end else if (done) begin
        break;
      end
      if (cyc > 2000) begin
        total++;
        bad++;
        $display("FAIL timeout got=%0d want<=%0d", cyc, 2000);
        break;
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Driver: directed vectors with hand-computed expectations
  initial begin
    clr_in();
    reset = 1'b0;
    @(posedge clk); #1;
    step("reset_state", 0, 0, 4'd0, 0);
    reset = 1'b1;
    step("idle", 0, 0, 4'd0, 0);

    // register hazards
    RegWrite_E = 1; A3_E = 5'd8; tnew_E = 2'd2; rs_D = 5'd8; tuse_rs_D = 2'd1;
    step("load_use", 1, 0, 4'd0, 0);
    tnew_E = 2'd1;
    step("tnew_eq_tuse", 0, 0, 4'd0, 0);
    tuse_rs_D = 2'd0;
    step("tnew1_tuse0", 1, 0, 4'd0, 0);
    tuse_rs_D = 2'd3; tnew_E = 2'd2;
    step("tuse_none", 0, 0, 4'd0, 0);
    clr_in();
    RegWrite_M = 1; A3_M = 5'd5; tnew_M = 2'd1; rt_D = 5'd5; tuse_rt_D = 2'd0;
    step("m_rt", 1, 0, 4'd0, 0);
    RegWrite_M = 0;
    step("m_nowrite", 0, 0, 4'd0, 0);
    RegWrite_M = 1; A3_M = 5'd0; tnew_M = 2'd2; rt_D = 5'd0;
    step("zero_reg", 0, 0, 4'd0, 0);
    RegWrite_E = 1; A3_E = 5'd0; tnew_E = 2'd2;
    step("zero_reg_em", 0, 0, 4'd0, 0);
    clr_in();
    RegWrite_E = 1; A3_E = 5'd9; tnew_E = 2'd2;
    RegWrite_M = 1; A3_M = 5'd9; tnew_M = 2'd0;
    rs_D = 5'd9; tuse_rs_D = 2'd0;
    step("e_only", 1, 0, 4'd0, 0);
    tnew_E = 2'd0; tnew_M = 2'd1;
    step("m_only", 1, 0, 4'd0, 0);
    tnew_M = 2'd0;
    step("both_ready", 0, 0, 4'd0, 0);
    A3_E = 5'd10; A3_M = 5'd10; tnew_E = 2'd2; tnew_M = 2'd2;
    step("reg_mismatch", 0, 0, 4'd0, 0);

    // mult then mflo
    clr_in();
    reset = 1'b0;
    step("rst_pre_mult", 0, 0, 4'd0, 0);
    reset = 1'b1;
    md_start_E = 1; md_use_D = 1;
    step("mult_start", 1, 0, 4'd0, 0);
    md_start_E = 0;
    for (int k = 5; k >= 1; k--) step("mult_busy", 1, 1, 4'(k), 0);
    step("mult_done", 0, 0, 4'd0, 0);

    // div with a start while busy
    md_use_D = 0; md_start_E = 1; md_div_E = 1;
    step("div_start", 0, 0, 4'd0, 0);
    md_start_E = 0; md_div_E = 0;
    for (int k = 10; k >= 8; k--) step("div_busy", 0, 1, 4'(k), 0);
    md_start_E = 1;
    step("div_restart", 0, 1, 4'd7, 0);
    md_start_E = 0;
    for (int k = 6; k >= 1; k--) step("div_busy_err", 0, 1, 4'(k), 1);
    step("div_done", 0, 0, 4'd0, 1);
    step("err_sticky", 0, 0, 4'd0, 1);

    // reset in the middle of a div
    md_use_D = 1; md_start_E = 1; md_div_E = 1;
    step("div2_start", 1, 0, 4'd0, 1);
    md_start_E = 0; md_div_E = 0;
    for (int k = 10; k >= 4; k--) step("div2_busy", 1, 1, 4'(k), 1);
    reset = 1'b0;
    step("rst_mid_div", 0, 0, 4'd0, 0);
    RegWrite_E = 1; A3_E = 5'd8; tnew_E = 2'd2; rs_D = 5'd8; tuse_rs_D = 2'd1;
    step("rst_comb_stall", 1, 0, 4'd0, 0);
    clr_in();
    md_use_D = 1;
    reset = 1'b1;
    step("post_rst_mdu", 0, 0, 4'd0, 0);

    // stall counter saturation
    clr_in();
    RegWrite_E = 1; A3_E = 5'd8; tnew_E = 2'd2; rs_D = 5'd8; tuse_rs_D = 2'd1;
    force dut.stall_q = 32'hFFFF_FFFD;
    #1;
    release dut.stall_q;
    exp_scnt = 32'hFFFF_FFFD;
    step("sat_fd", 1, 0, 4'd0, 0);
    step("sat_fe", 1, 0, 4'd0, 0);
    step("sat_ff", 1, 0, 4'd0, 0);
    step("sat_hold", 1, 0, 4'd0, 0);
    clr_in();
    step("sat_idle", 0, 0, 4'd0, 0);

    done = 1'b1;
  end

endmodule
